// File: rtl/squeeze_dump_buffer.sv
// Keccak output stage: buffers up to DEPTH rate blocks and streams them as W-bit words.
// Optional keep_out byte-enable port is enabled by defining SQUEEZE_DUMP_KEEP_EN.
module squeeze_dump_buffer #(
    parameter int unsigned W        = 64,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned RATE_MAX = 1344
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [31:0]         output_size,
    input  logic [1:0]          operation_mode,
    input  logic [RATE_MAX-1:0] blk_data,
    input  logic                blk_we,
    output logic                blk_ready,
    output logic                last_block,
    output logic [W-1:0]        data_out,
    output logic                valid_out,
    input  logic                ready_in,
    output logic                last_out,
`ifdef SQUEEZE_DUMP_KEEP_EN
    output logic [W/8-1:0]      keep_out,
`endif
    output logic                done
);

    localparam int NW = RATE_MAX / W;
    localparam int IW = $clog2(NW);
    localparam int KW = W / 8;
    localparam int TW = (KW > 1) ? $clog2(KW) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SH = $clog2(W);

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

    state_e          r_state, w_state_d;
    logic [1:0]      r_mode;
    logic [31:0]     r_words_left;
    logic [31:0]     r_uncov;
    logic [TW-1:0]   r_tail;
    logic [IW-1:0]   r_idx;
    logic [PW-1:0]   r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [W-1:0]    r_slot [DEPTH][NW];

    logic [31:0]     w_size_eff, w_words_calc, w_rate_words;
    logic [TW-1:0]   w_tail_calc;
    logic [IW-1:0]   w_last_idx;
    logic            w_xfer, w_final, w_push, w_pop;
    logic [KW-1:0]   w_keep;
    logic [W-1:0]    w_word;
    logic            w_unused_size;

    function automatic logic [IW-1:0] f_last_idx(input logic [1:0] mode);
        case (mode)
            2'd0:       return IW'(RATE_MAX / W - 1);
            2'd1, 2'd2: return IW'(1088 / W - 1);
            default:    return IW'(576 / W - 1);
        endcase
    endfunction

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    // Size is byte-granular; the low three bits carry no information.
    assign w_unused_size = ^output_size[2:0];
    assign w_size_eff    = {output_size[31:3], 3'b000};
    assign w_words_calc  = 32'((33'(w_size_eff) + 33'(W - 1)) >> SH);
    assign w_tail_calc   = TW'((output_size >> 3) % KW);

    assign w_last_idx   = f_last_idx(r_mode);
    assign w_rate_words = 32'(w_last_idx) + 32'd1;

    assign cmd_ready  = (r_state == StIdle);
    assign done       = (r_state == StDone);
    assign valid_out  = (r_state == StStream) && (r_count != '0);
    assign blk_ready  = (r_state == StStream) && (r_count < CW'(DEPTH));
    assign last_block = (r_state == StStream) && (r_uncov == '0);
    assign w_final    = (r_words_left == 32'd1);
    assign last_out   = valid_out && w_final;
    assign w_xfer     = valid_out && ready_in;
    // A block arriving with the final transfer would only be flushed, so drop it.
    assign w_push     = blk_we && blk_ready && !(w_xfer && w_final);
    assign w_pop      = w_xfer && !w_final && (r_idx == w_last_idx);

    always_comb begin
        w_keep = '1;
        if (w_final && (r_tail != '0)) begin
            for (int b = 0; b < KW; b++) w_keep[b] = (b < int'(r_tail));
        end
        w_word   = r_slot[r_rd_ptr][r_idx];
        data_out = '0;
        if (valid_out) begin
            for (int b = 0; b < KW; b++) begin
                if (w_keep[b]) data_out[b*8 +: 8] = w_word[b*8 +: 8];
            end
        end
    end

`ifdef SQUEEZE_DUMP_KEEP_EN
    assign keep_out = valid_out ? w_keep : '0;
`endif

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:   if (cmd_valid) w_state_d = (w_size_eff == '0) ? StDone : StStream;
            StStream: if (w_xfer && w_final) w_state_d = StDone;
            StDone:   w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode       <= '0;
            r_words_left <= '0;
            r_uncov      <= '0;
            r_tail       <= '0;
            r_idx        <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (cmd_valid) begin
                        r_mode       <= operation_mode;
                        r_words_left <= w_words_calc;
                        r_uncov      <= w_words_calc;
                        r_tail       <= w_tail_calc;
                    end
                end
                StStream: begin
                    if (w_xfer && !w_final) begin
                        r_words_left <= r_words_left - 32'd1;
                        r_idx        <= w_pop ? '0 : r_idx + IW'(1);
                    end
                    if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
                    if (w_push) begin
                        r_wr_ptr <= f_inc(r_wr_ptr);
                        r_uncov  <= (r_uncov > w_rate_words) ? r_uncov - w_rate_words : '0;
                    end
                    if (w_push && !w_pop) begin
                        r_count <= r_count + CW'(1);
                    end else if (w_pop && !w_push) begin
                        r_count <= r_count - CW'(1);
                    end
                end
                default: begin
                    // Flush: unread words are discarded and the slot FIFO empties.
                    r_words_left <= '0;
                    r_uncov      <= '0;
                    r_idx        <= '0;
                    r_rd_ptr     <= '0;
                    r_wr_ptr     <= '0;
                    r_count      <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int j = 0; j < NW; j++) r_slot[r_wr_ptr][j] <= blk_data[j*W +: W];
        end
    end

endmodule

// File: tb/tb_squeeze_dump_buffer.sv
// Directed self-checking bench for squeeze_dump_buffer (W=64, DEPTH=2).
module tb_squeeze_dump_buffer;

    localparam int W  = 64;
    localparam int RM = 1344;

    logic          clk, rst;
    logic          cmd_valid, cmd_ready;
    logic [31:0]   output_size;
    logic [1:0]    operation_mode;
    logic [RM-1:0] blk_data;
    logic          blk_we, blk_ready, last_block;
    logic [W-1:0]  data_out;
    logic          valid_out, ready_in, last_out, done;
`ifdef SQUEEZE_DUMP_KEEP_EN
    logic [W/8-1:0] keep_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    squeeze_dump_buffer #(.W(W), .DEPTH(2), .RATE_MAX(RM)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .output_size    (output_size),
        .operation_mode (operation_mode),
        .blk_data       (blk_data),
        .blk_we         (blk_we),
        .blk_ready      (blk_ready),
        .last_block     (last_block),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .last_out       (last_out),
`ifdef SQUEEZE_DUMP_KEEP_EN
        .keep_out       (keep_out),
`endif
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word j of block p: block number in the top byte, 0xA0+j in the low byte.
    function automatic logic [63:0] pat(input int p, input int j);
        return {8'(p), 48'h5A5A_5A5A_5A5A, 8'(8'hA0 + j)};
    endfunction

    function automatic logic [RM-1:0] make_blk(input int p);
        logic [RM-1:0] b;
        b = '0;
        for (int j = 0; j < RM / 64; j++) b[j*64 +: 64] = pat(p, j);
        return b;
    endfunction

    task automatic run_req(input int size, input int mode, input int exp_words,
                           input int exp_blocks, input int rw, input int tail,
                           input bit stall, input bit exp_br);
        int          got, pushed, cyc;
        bit          stalled_prev, push_now, rdy;
        logic [63:0] prev_data, exp_d, mask;
        got = 0; pushed = 0; cyc = 0; stalled_prev = 0; prev_data = '0;
        cmd_valid = 1'b1; output_size = 32'(size); operation_mode = 2'(mode);
        tick();
        check_eq("stream_cmd_ready", 64'(cmd_ready), 64'd0);
        check_eq("stream_blk_ready", 64'(blk_ready), 64'd1);
        check_eq("stream_valid0", 64'(valid_out), 64'd0);
        check_eq("stream_last_block0", 64'(last_block), 64'd0);
        // A command outside IDLE must be ignored.
        output_size = 32'd0; operation_mode = 2'(3 - mode);
        while (got < exp_words && cyc < 400) begin
            rdy = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            if (stalled_prev) begin
                check_eq("hold_valid", 64'(valid_out), 64'd1);
                check_eq("hold_data", data_out, prev_data);
            end
            ready_in = rdy;
            blk_we   = (pushed < exp_blocks);
            blk_data = make_blk(pushed);
            if (valid_out && rdy) begin
                exp_d = pat(got / rw, got % rw);
                if (got == exp_words - 1 && tail != 0) begin
                    mask  = (64'h1 << (tail * 8)) - 64'h1;
                    exp_d = exp_d & mask;
                end
                check_eq($sformatf("word%0d", got), data_out, exp_d);
                check_eq($sformatf("last_out%0d", got), 64'(last_out), 64'(got == exp_words - 1));
`ifdef SQUEEZE_DUMP_KEEP_EN
                check_eq($sformatf("keep%0d", got), 64'(keep_out),
                         (got == exp_words - 1 && tail != 0) ? 64'((1 << tail) - 1) : 64'hFF);
`endif
                got++;
            end
            push_now = blk_we && blk_ready;
            if (push_now) pushed++;
            stalled_prev = valid_out && !rdy;
            prev_data    = data_out;
            tick();
            cmd_valid = 1'b0;
            cyc++;
            if (push_now) begin
                check_eq($sformatf("last_block_p%0d", pushed), 64'(last_block),
                         64'(pushed == exp_blocks));
                if (pushed == exp_blocks)
                    check_eq("blk_ready_after_last_push", 64'(blk_ready), 64'(exp_br));
            end
        end
        blk_we = 1'b0; ready_in = 1'b0; cmd_valid = 1'b0;
        check_eq("words_transferred", 64'(got), 64'(exp_words));
        check_eq("blocks_pushed", 64'(pushed), 64'(exp_blocks));
        check_eq("done_pulse", 64'(done), 64'd1);
        check_eq("done_valid", 64'(valid_out), 64'd0);
        check_eq("done_blk_ready", 64'(blk_ready), 64'd0);
        tick();
        check_eq("done_clear", 64'(done), 64'd0);
        check_eq("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; output_size = '0; operation_mode = '0;
        blk_data = '0; blk_we = 1'b0; ready_in = 1'b0;
        #3 rst = 1'b0;
        tick();
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("rst_blk_ready", 64'(blk_ready), 64'd0);
        check_eq("rst_valid", 64'(valid_out), 64'd0);
        check_eq("rst_data", data_out, 64'd0);
        check_eq("rst_last_out", 64'(last_out), 64'd0);
        check_eq("rst_last_block", 64'(last_block), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        rst = 1'b1;
        tick();

        // size, mode, words, blocks, rate_words, tail bytes, stall, blk_ready after final push
        run_req(256, 0, 4, 1, 21, 0, 1'b0, 1'b1);
        run_req(1600, 3, 25, 3, 9, 0, 1'b0, 1'b0);
        run_req(100, 1, 2, 1, 17, 4, 1'b0, 1'b1);
        run_req(40, 2, 1, 1, 17, 5, 1'b0, 1'b1);
        run_req(1408, 0, 22, 2, 21, 0, 1'b0, 1'b0);
        run_req(1600, 3, 25, 3, 9, 0, 1'b1, 1'b0);

        // Zero-length request.
        cmd_valid = 1'b1; output_size = 32'd0; operation_mode = 2'd0;
        tick();
        cmd_valid = 1'b0;
        check_eq("size0_done", 64'(done), 64'd1);
        check_eq("size0_valid", 64'(valid_out), 64'd0);
        tick();
        check_eq("size0_done_clear", 64'(done), 64'd0);
        check_eq("size0_cmd_ready", 64'(cmd_ready), 64'd1);

        // Reset in the middle of a stream.
        cmd_valid = 1'b1; output_size = 32'd1600; operation_mode = 2'd3;
        tick();
        cmd_valid = 1'b0; blk_we = 1'b1; blk_data = make_blk(0);
        tick();
        blk_we = 1'b0; ready_in = 1'b1;
        tick();
        tick();
        check_eq("mid_valid", 64'(valid_out), 64'd1);
        check_eq("mid_data", data_out, pat(0, 2));
        rst = 1'b0;
        #1;
        check_eq("abort_valid", 64'(valid_out), 64'd0);
        check_eq("abort_data", data_out, 64'd0);
        check_eq("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("abort_blk_ready", 64'(blk_ready), 64'd0);
        check_eq("abort_last_block", 64'(last_block), 64'd0);
        ready_in = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        run_req(256, 0, 4, 1, 21, 0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
